serial_adder: RTL and testbench

Bit-serial adder/subtractor that drives one `full_adder` cell one bit per clock. It loads two WIDTH-bit operands on a start pulse and shifts them LSB-first through the cell, feeding the registered carry back into `cin`. It collects `sum` bits into a result register and reports completion with a one-cycle `done` pulse. It sits directly upstream of the `full_adder` cell, sequencing its inputs, and consumes the cell's `sum`/`cout` outputs.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 16 +
 rtl/serial_adder.sv | 86 ++++++++
 tb/tb_serial_adder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default operand width.
// Pure declarations; no logic, no latency.
package serial_adder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell built from gates; combinational, zero latency, no flow control.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic xy_x;

  assign xy_x = x ^ y;
  assign sum  = xy_x ^ cin;
  assign cout = (x & y) | (cin & xy_x);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract of two WIDTH-bit words through one full_adder cell, LSB first.
// Result and one-cycle done pulse appear WIDTH clocks after start; start is ignored while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            sum   <= {fa_sum, s_sr[WIDTH-1:1]};
            cout  <= fa_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after an edge; applies operands, lets E0 sample them, returns #1 after E0.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb);
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen #1 after an edge; 0 means the bound expired.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input logic [7:0] es, input logic ec);
    int n;
    start_op(av, bv, ci, sb);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int d0;

    // Reset held with start asserted: reset must win.
    start = 1'b1; a = 8'h3C; b = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'h00);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    run_op("add1", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0);
    chk("done_clear", 32'(done), 32'd0);
    run_op("add2", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub2", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op("add3", 8'hA5, 8'h5B, 1'b1, 1'b0, 8'h01, 1'b1);

    // start re-pulsed mid-operation must not disturb the operation.
    d0 = done_cnt;
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("prot_lat", n, 5);
    chk("prot_sum", 32'(sum), 32'h96);
    repeat (12) @(posedge clk);
    #1;
    chk("prot_pulses", done_cnt - d0, 1);
    chk("prot_busy", 32'(busy), 32'd0);

    // Back-to-back: start held during the done cycle.
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    wait_done(n);
    chk("b2b_lat1", n, 8);
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold", 32'(sum), 32'h96);
    n = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("b2b_lat2", n, 9);
    chk("b2b_sum", 32'(sum), 32'h02);
    @(posedge clk); #1;

    // Abort with reset at cycle 4 of an operation.
    d0 = done_cnt;
    start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum",  32'(sum),  32'h00);
    chk("abort_done", 32'(done), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt - d0, 0);
    run_op("post", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
